seg7_display_driver: RTL
========================

Name: seg7_display_driver

Overview:
- Downstream of the output-reader stage: takes its 32-bit `out` word and drives the board's 8-digit multiplexed seven-segment display.
- Each new word is latched and converted to eight digit codes, either hex nibbles or decimal via sequential double-dabble.
- The digits are time-multiplexed onto shared active-low segment and anode lines, with leading-zero blanking.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit is held before advancing to the next (legal range ≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  32  value to display (output-reader `out`).
- dec_mode_i  input  1  0 = hex display, 1 = unsigned decimal display.
- seg_o  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp always 1.
- an_o  output  8  active-low digit enables, one-hot low; bit 0 = rightmost digit.
- busy_o  output  1  high while a conversion is in progress.

Behaviour:
- Registers:
  - shown_q[31:0] and mode_q: last accepted value and mode.
  - src_q: working copy of the accepted value.
  - bcd_q[31:0]: double-dabble accumulator.
  - dig_q[8][4:0]: committed digit codes.
  - fsm state, prescaler, scan index idx[2:0].
- Reset (async, immediate, aborts any conversion):
  - state IDLE, shown_q=0, mode_q=0, all dig_q=0.
  - prescaler=0, idx=0, busy_o=0, an_o=8'hFE, seg_o=8'hC0.
- FSM states: IDLE, HEX, DEC, COMMIT.
- IDLE:
  - If (data_i != shown_q) or (dec_mode_i != mode_q) at edge N: load shown_q/src_q/mode_q and set busy_o=1.
  - Next state: HEX if mode 0; COMMIT with overflow flag if mode 1 and data_i ≥ 100_000_000; DEC otherwise, with bcd_q=0 and counter=0.
- HEX: edge N+1 writes dig_q[k]=src_q[4k+3:4k], clears busy_o, returns to IDLE.
- DEC:
  - One double-dabble iteration per clk, 32 iterations on edges N+1..N+32.
  - Each iteration: add 3 to every BCD nibble ≥5, then shift {bcd_q,src_q} left by 1.
  - Next state COMMIT.
- COMMIT: edge N+33 (or N+1 for overflow) writes dig_q from bcd_q, or all "dash" on overflow; clears busy_o; returns to IDLE.
- busy_o high durations: hex 1 cycle; decimal 33 cycles; decimal overflow 1 cycle.
- data_i/dec_mode_i changes while busy are ignored. On return to IDLE the comparison with shown_q re-triggers, so the last value always wins. No back-to-back loss.
- dig_q updates atomically at commit only; the display shows the previous value during conversion.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, idx increments mod 8.
  - an_o and seg_o are registered and change on the same edge as idx (1-cycle latency from idx).
- Leading-zero blanking: any digit position above the most-significant non-zero digit outputs seg_o=8'hFF. Digit 0 is never blanked, so value 0 shows "0". Dash pattern is never blanked.
- Segment codes (active low):
  - Digits 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - Hex A-F: 88 83 C6 A1 86 8E.
  - Dash: BF. Blank: FF.

Test Plan (SCAN_DIV=4):
- Reset release with data_i=0: an_o=FE, seg_o=C0, busy_o=0 → after 4 clks an_o=FD, seg_o=FF; sequence wraps back to FE after 32 clks.
- Hex: data_i=32'h0000_1A2F, dec_mode_i=0 → busy_o high exactly 1 clk; over one scan frame digits 0..7 = 8E, A4, 88, F9, FF, FF, FF, FF.
- Decimal: data_i=12345678, dec_mode_i=1 → busy_o high exactly 33 clks; frame = 80, F8, 82, 92, 99, B0, A4, F9.
- Decimal boundary and overflow:
  - 99999999 → all digits 90 after 33 busy clks.
  - 100000000 → all digits BF, busy_o 1 clk.
  - 0 → C0 then seven FF.
- Change mid-conversion: dec 42, then data_i=7 on busy clk 10 → first commit displays 42 (A4, 99, blanks); busy_o falls for 1 clk, rises for 33 more; final display 7 (F8, blanks).
- Async reset asserted at busy clk 20 → same-cycle outputs return to reset values without a clock edge; no commit of the partial result; after release the current data_i is reconverted.

Source files
------------

// File: rtl/seg7_display_driver.sv
// rtl/seg7_display_driver.sv - 8-digit multiplexed seven-segment driver with hex/decimal conversion
//
// Latches each new 32-bit value, converts it to eight digit codes (hex nibbles
// or decimal via sequential double-dabble) and scans them onto shared
// active-low segment and anode lines with leading-zero blanking.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   data_i     value to display
//   dec_mode_i 0 = hex, 1 = unsigned decimal
//   seg_o      active-low segments {dp,g,f,e,d,c,b,a}, dp always 1
//   an_o       active-low one-hot digit enable, bit 0 = rightmost digit
//   busy_o     high while a conversion is in progress

module seg7_display_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        dec_mode_i,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        busy_o
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    // Digit code 16 is the overflow dash; 0..15 are plain nibble values.
    localparam logic [4:0] DASH_CODE = 5'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEX    = 2'd1,
        DEC    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t          r_state, w_state_n;
    logic [31:0]     r_shown, w_shown_n;
    logic            r_mode,  w_mode_n;
    logic [31:0]     r_src,   w_src_n;
    logic [31:0]     r_bcd,   w_bcd_n;
    logic [4:0]      r_cnt,   w_cnt_n;
    logic            r_ovf,   w_ovf_n;
    logic [7:0][4:0] r_dig,   w_dig_n;
    logic            r_busy,  w_busy_n;
    logic [63:0]     w_dd;

    logic [PW-1:0]   r_pre;
    logic [2:0]      r_idx;
    logic [7:0]      r_seg, r_an;
    logic            w_wrap;
    logic [2:0]      w_idx_n;
    logic [2:0]      w_msd;
    logic [7:0]      w_seg_n;
    logic [7:0]      w_an_n;

    function automatic logic [31:0] add3(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input logic [4:0] code);
        logic [7:0] s;
        case (code)
            5'd0:    s = 8'hC0;
            5'd1:    s = 8'hF9;
            5'd2:    s = 8'hA4;
            5'd3:    s = 8'hB0;
            5'd4:    s = 8'h99;
            5'd5:    s = 8'h92;
            5'd6:    s = 8'h82;
            5'd7:    s = 8'hF8;
            5'd8:    s = 8'h80;
            5'd9:    s = 8'h90;
            5'd10:   s = 8'h88;
            5'd11:   s = 8'h83;
            5'd12:   s = 8'hC6;
            5'd13:   s = 8'hA1;
            5'd14:   s = 8'h86;
            5'd15:   s = 8'h8E;
            5'd16:   s = 8'hBF;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Conversion FSM: next-state and datapath next values.
    always_comb begin
        w_state_n = r_state;
        w_shown_n = r_shown;
        w_mode_n  = r_mode;
        w_src_n   = r_src;
        w_bcd_n   = r_bcd;
        w_cnt_n   = r_cnt;
        w_ovf_n   = r_ovf;
        w_dig_n   = r_dig;
        w_busy_n  = r_busy;
        w_dd      = '0;
        case (r_state)
            IDLE: begin
                // Comparing against the accepted value (not a change edge)
                // means a value that arrived while busy is picked up here.
                if ((data_i != r_shown) || (dec_mode_i != r_mode)) begin
                    w_shown_n = data_i;
                    w_src_n   = data_i;
                    w_mode_n  = dec_mode_i;
                    w_busy_n  = 1'b1;
                    if (!dec_mode_i) begin
                        w_state_n = HEX;
                    end else if (data_i >= 32'd100_000_000) begin
                        w_ovf_n   = 1'b1;
                        w_state_n = COMMIT;
                    end else begin
                        w_ovf_n   = 1'b0;
                        w_bcd_n   = '0;
                        w_cnt_n   = '0;
                        w_state_n = DEC;
                    end
                end
            end
            HEX: begin
                for (int k = 0; k < 8; k++)
                    w_dig_n[k] = {1'b0, r_src[4*k +: 4]};
                w_busy_n  = 1'b0;
                w_state_n = IDLE;
            end
            DEC: begin
                w_dd      = {add3(r_bcd), r_src} << 1;
                w_bcd_n   = w_dd[63:32];
                w_src_n   = w_dd[31:0];
                w_cnt_n   = r_cnt + 5'd1;
                if (r_cnt == 5'd31)
                    w_state_n = COMMIT;
            end
            COMMIT: begin
                for (int k = 0; k < 8; k++)
                    w_dig_n[k] = r_ovf ? DASH_CODE : {1'b0, r_bcd[4*k +: 4]};
                w_busy_n  = 1'b0;
                w_state_n = IDLE;
            end
            default: begin
                w_busy_n  = 1'b0;
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shown <= '0;
            r_mode  <= 1'b0;
            r_src   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_dig   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_shown <= w_shown_n;
            r_mode  <= w_mode_n;
            r_src   <= w_src_n;
            r_bcd   <= w_bcd_n;
            r_cnt   <= w_cnt_n;
            r_ovf   <= w_ovf_n;
            r_dig   <= w_dig_n;
            r_busy  <= w_busy_n;
        end
    end

    // Scan: outputs are computed from the upcoming index so they move on the
    // same edge as idx, and are refreshed every cycle so a commit shows up
    // without waiting for the next digit advance.
    always_comb begin
        w_wrap  = (r_pre == PW'(SCAN_DIV - 1));
        w_idx_n = w_wrap ? r_idx + 3'd1 : r_idx;
        w_msd   = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_dig[k] != 5'd0)
                w_msd = 3'(k);
        end
        w_seg_n = (w_idx_n > w_msd) ? 8'hFF : seg_of(r_dig[w_idx_n]);
        w_an_n  = ~(8'b1 << w_idx_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
            r_seg <= 8'hC0;
            r_an  <= 8'hFE;
        end else begin
            r_pre <= w_wrap ? '0 : r_pre + PW'(1);
            r_idx <= w_idx_n;
            r_seg <= w_seg_n;
            r_an  <= w_an_n;
        end
    end

    assign seg_o  = r_seg;
    assign an_o   = r_an;
    assign busy_o = r_busy;

endmodule
